// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared constants and small decode helpers for the RV32M multiply/divide
// sequencer (muldiv_ctrl):
//   - RV32M funct3 codes (F3_*)
//   - sequencer FSM state encodings (MD_*)
//   - ALU operation codes used while the sequencer owns the shared ALU
//   - funct3 decode helpers and a conditional two's-complement magnitude helper
// Optional feature macro used by muldiv_ctrl: MULDIV_EARLY_OUT_EN
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Sequencer FSM states
    localparam logic [2:0] MD_IDLE  = 3'd0;
    localparam logic [2:0] MD_PREP  = 3'd1;
    localparam logic [2:0] MD_ITER  = 3'd2;
    localparam logic [2:0] MD_FIX   = 3'd3;
    localparam logic [2:0] MD_NEGHI = 3'd4;
    localparam logic [2:0] MD_DONE  = 3'd5;

    // ALU operations, {class, sub}: only ADD and SUB are used here
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // Multiply family (MUL, MULH, MULHSU, MULHU)
    function automatic logic fn_is_mul(input logic [2:0] fn);
        return ~fn[2];
    endfunction

    // Remainder family (REM, REMU)
    function automatic logic fn_is_rem(input logic [2:0] fn);
        return fn[2] & fn[1];
    endfunction

    // Multiplies whose result is the upper product word
    function automatic logic fn_is_mulh(input logic [2:0] fn);
        return ~fn[2] & (fn[1] | fn[0]);
    endfunction

    // rs1 is interpreted as signed
    function automatic logic fn_a_signed(input logic [2:0] fn);
        return (fn == F3_MULH) || (fn == F3_MULHSU) || (fn == F3_DIV) || (fn == F3_REM);
    endfunction

    // rs2 is interpreted as signed
    function automatic logic fn_b_signed(input logic [2:0] fn);
        return (fn == F3_MULH) || (fn == F3_DIV) || (fn == F3_REM);
    endfunction

    // Two's-complement negate when neg is set, pass through otherwise
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle RV32M multiply/divide sequencer. While busy it owns the shared
// 32-bit ALU and drives alu_a/alu_b/alu_op every cycle; the ALU result comes
// back combinationally in the same cycle. Multiplies use radix-2 shift-add,
// divides use restoring shift-subtract, both on operand magnitudes, followed
// by a sign-fix step (and an upper-word negate step for signed MULH/MULHSU).
//
// Ports
//   clk         in   clock, all state on rising edge
//   rst         in   synchronous active-high reset
//   start       in   request, accepted only in IDLE
//   funct3      in   RV32M operation select
//   op_a, op_b  in   rs1/rs2 values, sampled on accepted start
//   abort       in   flush, cancels any operation in flight
//   busy        out  high from the cycle after accept through DONE
//   done        out  one-cycle pulse, result valid
//   result      out  final value, held until the next completion
//   alu_own     out  block owns the ALU this cycle (same as busy)
//   alu_a/alu_b out  ALU operands
//   alu_op      out  ALU operation (ADD or SUB)
//   alu_result  in   combinational ALU result
//
// Optional feature: MULDIV_EARLY_OUT_EN
//   defined   - MUL* with a zero magnitude operand finishes from PREP with 0;
//               DIV*/REM* with |a| < |b| skips the iterations (q=0, r=a).
//   undefined - every non-special operation takes all 32 iterations.
//
// The ALU operand outputs are registered: they are computed from the
// next-state values so that in each cycle they match the current state.
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result
);

    logic [2:0]  state_q, state_d, state_nx;
    logic [2:0]  fn_q, fn_d;
    logic [31:0] a_q, a_d;          // raw rs1, needed for the div-by-zero remainder
    logic [31:0] b_q, b_d;          // raw rs2
    logic [31:0] hi_q, hi_d;        // upper product word
    logic [31:0] lo_q, lo_d;        // multiplier / lower product, or dividend / quotient
    logic [31:0] rem_q, rem_d;      // partial remainder
    logic [31:0] dvs_q, dvs_d;      // multiplicand or divisor magnitude
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;      // final value must be negated
    logic [31:0] result_q, result_d, result_nx;
    logic        busy_q, done_q;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;

    logic        sgn_a, sgn_b;
    logic [31:0] mag_a, mag_b;
    logic        div_ovf;
    logic        mul_carry;
    logic [32:0] div_sh;
    logic        div_acc;
    logic [31:0] fix_x;

    assign sgn_a   = fn_a_signed(fn_q) & a_q[31];
    assign sgn_b   = fn_b_signed(fn_q) & b_q[31];
    assign mag_a   = magnitude(a_q, sgn_a);
    assign mag_b   = magnitude(b_q, sgn_b);
    assign div_ovf = ((fn_q == F3_DIV) || (fn_q == F3_REM)) &&
                     (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    // Sequencer next state and datapath register updates
    always_comb begin
        state_nx  = state_q;
        fn_d      = fn_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        result_nx = result_q;
        mul_carry = 1'b0;
        div_sh    = 33'd0;
        div_acc   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_nx = MD_PREP;
                    fn_d     = funct3;
                    a_d      = op_a;
                    b_d      = op_b;
                end else begin
                    state_nx = MD_IDLE;
                end
            end
            MD_PREP: begin
                cnt_d = 5'd0;
                hi_d  = 32'd0;
                rem_d = 32'd0;
                if (fn_is_mul(fn_q)) begin
                    neg_d    = sgn_a ^ sgn_b;
                    lo_d     = mag_b;
                    dvs_d    = mag_a;
`ifdef MULDIV_EARLY_OUT_EN
                    state_nx  = ((mag_a == 32'd0) || (mag_b == 32'd0)) ? MD_DONE : MD_ITER;
                    result_nx = ((mag_a == 32'd0) || (mag_b == 32'd0)) ? 32'd0 : result_q;
`else
                    state_nx = MD_ITER;
`endif
                end else begin
                    // remainder takes the dividend sign, quotient the xor of both
                    neg_d = fn_is_rem(fn_q) ? sgn_a : (sgn_a ^ sgn_b);
                    lo_d  = mag_a;
                    dvs_d = mag_b;
                    if (b_q == 32'd0) begin
                        state_nx  = MD_DONE;
                        result_nx = fn_is_rem(fn_q) ? a_q : 32'hFFFF_FFFF;
                    end else if (div_ovf) begin
                        state_nx  = MD_DONE;
                        result_nx = fn_is_rem(fn_q) ? 32'd0 : 32'h8000_0000;
                    end else begin
`ifdef MULDIV_EARLY_OUT_EN
                        // small dividend: quotient 0, remainder is the dividend
                        state_nx = (mag_a < mag_b) ? MD_FIX : MD_ITER;
                        lo_d     = (mag_a < mag_b) ? 32'd0 : mag_a;
                        rem_d    = (mag_a < mag_b) ? mag_a : 32'd0;
`else
                        state_nx = MD_ITER;
`endif
                    end
                end
            end
            MD_ITER: begin
                cnt_d = cnt_q + 5'd1;
                if (fn_is_mul(fn_q)) begin
                    // ALU adds hi + (lsb ? mcand : 0); wrap-around means carry out
                    mul_carry = (alu_result < hi_q);
                    hi_d      = {mul_carry, alu_result[31:1]};
                    lo_d      = {alu_result[0], lo_q[31:1]};
                end else begin
                    div_sh  = {rem_q, lo_q[31]};
                    div_acc = (div_sh >= {1'b0, dvs_q});
                    rem_d   = div_acc ? alu_result : div_sh[31:0];
                    lo_d    = {lo_q[30:0], div_acc};
                end
                state_nx = (cnt_q == 5'd31) ? MD_FIX : MD_ITER;
            end
            MD_FIX: begin
                if (fn_is_rem(fn_q)) begin
                    rem_d = alu_result;
                end else begin
                    lo_d = alu_result;
                end
                if (fn_is_mulh(fn_q)) begin
                    if (neg_q) begin
                        state_nx = MD_NEGHI;
                    end else begin
                        state_nx  = MD_DONE;
                        result_nx = hi_q;
                    end
                end else begin
                    state_nx  = MD_DONE;
                    result_nx = alu_result;
                end
            end
            MD_NEGHI: begin
                hi_d      = alu_result;
                result_nx = alu_result;
                state_nx  = MD_DONE;
            end
            MD_DONE: begin
                state_nx = MD_IDLE;
            end
            default: begin
                state_nx = MD_IDLE;
            end
        endcase
        // abort cancels everything, including a completion due this edge
        state_d  = abort ? MD_IDLE : state_nx;
        result_d = abort ? result_q : result_nx;
    end

    // ALU operands for the cycle after this edge, derived from next state
    always_comb begin
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        fix_x    = fn_is_rem(fn_d) ? rem_d : lo_d;
        case (state_d)
            MD_ITER: begin
                if (fn_is_mul(fn_d)) begin
                    alu_a_d  = hi_d;
                    alu_b_d  = lo_d[0] ? dvs_d : 32'd0;
                    alu_op_d = ALU_ADD;
                end else begin
                    alu_a_d  = {rem_d[30:0], lo_d[31]};
                    alu_b_d  = dvs_d;
                    alu_op_d = ALU_SUB;
                end
            end
            MD_FIX: begin
                if (neg_d) begin
                    alu_a_d  = 32'd0;
                    alu_b_d  = fix_x;
                    alu_op_d = ALU_SUB;
                end else begin
                    alu_a_d  = fix_x;
                    alu_b_d  = 32'd0;
                    alu_op_d = ALU_ADD;
                end
            end
            MD_NEGHI: begin
                // upper word of a 64-bit negate: ~hi plus borrow from the low word
                alu_a_d  = ~hi_d;
                alu_b_d  = {31'd0, (lo_d == 32'd0)};
                alu_op_d = ALU_ADD;
            end
            default: begin
                alu_a_d  = alu_a_q;
                alu_b_d  = alu_b_q;
                alu_op_d = alu_op_q;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            fn_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            alu_a_q  <= 32'd0;
            alu_b_q  <= 32'd0;
            alu_op_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            busy_q   <= (state_d != MD_IDLE);
            done_q   <= (state_d == MD_DONE);
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign busy    = busy_q;
    assign alu_own = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a behavioural ALU, an arithmetic
// reference model with a cycle-level completion tracker checked every cycle,
// and directed operations with hand-computed results and latencies.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done, alu_own;
    logic [31:0] result, alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;

    int errors = 0;
    int checks = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_MUL_ZERO  = 2;
    localparam int LAT_DIV_SMALL = 3;
`else
    localparam int LAT_MUL_ZERO  = 35;
    localparam int LAT_DIV_SMALL = 35;
`endif

    muldiv_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .alu_own   (alu_own),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // shared ALU
    always_comb alu_result = (alu_op == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (f)
            F3_MUL:    p = 64'(ua * ub);
            F3_MULH:   p = 64'(sa * sb) >> 32;
            F3_MULHSU: p = 64'(sa * ub) >> 32;
            F3_MULHU:  p = ({32'd0, a} * {32'd0, b}) >> 32;
            F3_DIV:    p = (b == 32'd0) ? 64'hFFFF_FFFF :
                           ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) ? 64'h8000_0000 : 64'(sa / sb);
            F3_DIVU:   p = (b == 32'd0) ? 64'hFFFF_FFFF : 64'(ua / ub);
            F3_REM:    p = (b == 32'd0) ? {32'd0, a} :
                           ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) ? 64'd0 : 64'(sa % sb);
            F3_REMU:   p = (b == 32'd0) ? {32'd0, a} : 64'(ua % ub);
            default:   p = 64'd0;
        endcase
        return p[31:0];
    endfunction

    // Cycle (counted from the start cycle) in which done must pulse
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic na, nb;
        logic [31:0] ma, mb;
        na = ((f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM)) && a[31];
        nb = ((f == F3_MULH) || (f == F3_DIV) || (f == F3_REM)) && b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        if (f >= F3_DIV) begin
            if (b == 32'd0) return 2;
            if (((f == F3_DIV) || (f == F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
`ifdef MULDIV_EARLY_OUT_EN
            if (ma < mb) return 3;
`endif
            return 35;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if ((ma == 32'd0) || (mb == 32'd0)) return 2;
`endif
        if (((f == F3_MULH) || (f == F3_MULHSU)) && (na ^ nb)) return 36;
        return 35;
    endfunction

    // Completion tracker: m_age is the cycle index within the current op
    int          m_age = 0;
    int          m_lat = 0;
    logic [31:0] m_pend = 32'd0;
    logic [31:0] m_result = 32'd0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_age    <= 0;
            m_result <= 32'd0;
            chk_en   <= 1'b1;
        end else if (m_age == 0) begin
            if (start && !abort) begin
                m_age  <= 1;
                m_lat  <= ref_lat(funct3, op_a, op_b);
                m_pend <= ref_res(funct3, op_a, op_b);
            end
        end else if (abort || (m_age == m_lat)) begin
            m_age <= 0;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_lat) m_result <= m_pend;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {63'd0, busy}, {63'd0, m_age != 0});
            check("alu_own", {63'd0, alu_own}, {63'd0, m_age != 0});
            check("done", {63'd0, done}, {63'd0, (m_age != 0) && (m_age == m_lat)});
            check("result", {32'd0, result}, {32'd0, m_result});
        end
    end

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        int own;
        n = 0;
        own = 0;
        funct3 = f;
        op_a = a;
        op_b = b;
        start = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (alu_own) own++;
            if (done) begin
                n = i;
                break;
            end
        end
        check({name, " latency"}, 64'(n), 64'(exp_lat));
        check({name, " value"}, {32'd0, result}, {32'd0, exp_res});
        check({name, " own cycles"}, 64'(own), 64'(exp_lat));
        @(negedge clk);
    endtask

    // Start an op, then cut it with abort or rst at cycle 11 (ITER cycle 10)
    task automatic cut_op(input string name, input bit use_rst, input logic [31:0] exp_after);
        int pulses;
        pulses = 0;
        funct3 = F3_MUL;
        op_a = 32'h0000_1234;
        op_b = 32'h0000_0010;
        start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) pulses++;
        end
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        abort = 1'b0;
        check({name, " busy after cut"}, {63'd0, busy}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check({name, " done pulses"}, 64'(pulses), 64'd0);
        check({name, " result kept"}, {32'd0, result}, {32'd0, exp_after});
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        check("reset alu_a", {32'd0, alu_a}, 64'd0);
        check("reset alu_b", {32'd0, alu_b}, 64'd0);
        check("reset alu_op", {60'd0, alu_op}, {60'd0, ALU_ADD});

        run_op("MUL 7xFFFFFFFD", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("MULH min*min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        run_op("MULHU ones", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        run_op("MULHSU -1x2", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 36);
        run_op("MULH lo zero", F3_MULH, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 36);
        run_op("DIV -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op("REM -7/2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op("REMU 7/2", F3_REMU, 32'd7, 32'd2, 32'd1, 35);

        cut_op("abort", 1'b0, 32'd1);
        run_op("MUL 3x4 after abort", F3_MUL, 32'd3, 32'd4, 32'd12, 35);
        cut_op("rst", 1'b1, 32'd0);
        run_op("MUL 3x4 after rst", F3_MUL, 32'd3, 32'd4, 32'd12, 35);

        run_op("DIVU 5/0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("REMU 5/0", F3_REMU, 32'd5, 32'd0, 32'd5, 2);
        run_op("DIV ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("REM ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
        run_op("DIVU 3/10", F3_DIVU, 32'd3, 32'd10, 32'd0, LAT_DIV_SMALL);
        run_op("REM -3/10", F3_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, LAT_DIV_SMALL);
        run_op("MUL 0x5", F3_MUL, 32'd0, 32'd5, 32'd0, LAT_MUL_ZERO);

        // start held high through most of the op; operands change after accept
        pulses = 0;
        funct3 = F3_MUL;
        op_a = 32'd3;
        op_b = 32'd5;
        start = 1'b1;
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            if (i == 10) op_a = 32'd9;
            if (i == 30) start = 1'b0;
            if (done) pulses++;
        end
        check("held start done pulses", 64'(pulses), 64'd1);
        check("held start value", {32'd0, result}, 64'd15);

        // start and abort together in IDLE: request dropped
        pulses = 0;
        funct3 = F3_MUL;
        op_a = 32'd6;
        op_b = 32'd7;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("start+abort done pulses", 64'(pulses), 64'd0);
        check("start+abort result", {32'd0, result}, 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
